// File: rtl/price_pkt_pkg.sv
// -----------------------------------------------------------------------------
// price_pkt_pkg
// Shared definitions for the price-feed packet: framing constants (also used
// by the arbitrage engine's receiver), packet length, byte-index enum and the
// serializer state enum.
// Build option: PRICE_PKT_CHECKSUM_EN adds an XOR checksum byte between B_lo
// and the footer (7-byte packet instead of 6).
// -----------------------------------------------------------------------------
package price_pkt_pkg;

  localparam logic [7:0] PKT_HEADER = 8'hAA;
  localparam logic [7:0] PKT_FOOTER = 8'h55;

`ifdef PRICE_PKT_CHECKSUM_EN
  localparam int PKT_BYTES = 7;
`else
  localparam int PKT_BYTES = 6;
`endif

  // Position of each byte within the packet.
  typedef enum logic [2:0] {
    IDX_HDR  = 3'd0,
    IDX_A_HI = 3'd1,
    IDX_A_LO = 3'd2,
    IDX_B_HI = 3'd3,
    IDX_B_LO = 3'd4,
`ifdef PRICE_PKT_CHECKSUM_EN
    IDX_CSUM = 3'd5,
    IDX_FTR  = 3'd6
`else
    IDX_FTR  = 3'd5
`endif
  } byte_idx_e;

  // Line states. The serializer walks IDLE..STOP; GAP is the packet-level
  // quiet time owned by the top.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_GAP   = 3'd4
  } ser_state_e;

  // Packet-level phase of price_packet_tx.
  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_SEND = 2'd1,
    PH_GAP  = 2'd2
  } pkt_phase_e;

endpackage

// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
// 8N1 UART transmitter for one byte at a time.
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   i_data       byte to send
//   i_valid      byte offered
//   o_ready      byte can be taken this cycle
//   o_tx         serial line, idle high
//   o_state      current ser_state_e value (debug)
// Handshake: a byte transfers on the rising edge where i_valid && o_ready;
// i_data is only sampled on that edge and the start bit is on the line the
// following cycle. o_ready is high while idle and also during the last cycle
// of the stop bit, so a byte offered then follows with no idle time.
// -----------------------------------------------------------------------------
module uart_tx_serializer
  import price_pkt_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_tx,
  output logic [2:0] o_state
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  ser_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_shift;
  logic [2:0]       r_bitn;
  logic             r_tx;

  logic w_bit_end;
  logic w_ready;
  logic w_load;

  // Counter restarts at zero on every bit boundary, so each bit is exactly
  // CLKS_PER_BIT cycles and no error builds up across frames.
  assign w_bit_end = (r_cnt == CNT_LAST);
  assign w_ready   = (r_state == ST_IDLE) || ((r_state == ST_STOP) && w_bit_end);
  assign w_load    = i_valid && w_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_bitn  <= '0;
      r_tx    <= 1'b1;
    end else if (w_load) begin
      r_shift <= i_data;
      r_cnt   <= '0;
      r_bitn  <= '0;
      r_tx    <= 1'b0;
      r_state <= ST_START;
    end else begin
      case (r_state)
        ST_IDLE: r_tx <= 1'b1;
        ST_START: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_tx    <= r_shift[0];
            r_state <= ST_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_bitn == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= ST_STOP;
            end else begin
              // LSB first: shift down and present the next bit
              r_bitn  <= r_bitn + 3'd1;
              r_shift <= r_shift >> 1;
              r_tx    <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_ready = w_ready;
  assign o_tx    = r_tx;
  assign o_state = r_state;

endmodule

// File: rtl/price_packet_tx.sv
// -----------------------------------------------------------------------------
// price_packet_tx
// Serializes one price-feed packet per request as 8N1 frames:
//   0xAA, A[15:8], A[7:0], B[15:8], B[7:0], [checksum,] 0x55
// Build option: PRICE_PKT_CHECKSUM_EN inserts A_hi^A_lo^B_hi^B_lo before the
// footer.
// Ports:
//   clk, rst         system clock, synchronous active-high reset
//   price_a/price_b  16-bit prices (cents), latched when a packet is accepted
//   send             request; accepted on the edge where send && ready
//   ready            a new packet can be accepted
//   uart_tx          serial line, idle high
//   busy             packet in flight, including the IDLE_BITS gap
//   pkt_done         one-cycle pulse as the packet completes
// Handshake: send/ready follow valid/ready rules; send while not ready is
// dropped, not queued. The start bit appears the cycle after acceptance.
// -----------------------------------------------------------------------------
module price_packet_tx
  import price_pkt_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 9600,
  parameter int IDLE_BITS = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] price_a,
  input  logic [15:0] price_b,
  input  logic        send,
  output logic        ready,
  output logic        uart_tx,
  output logic        busy,
  output logic        pkt_done
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int GAP_CYC      = IDLE_BITS * CLKS_PER_BIT;
  localparam int GAP_W        = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYC > 0) ? GAP_W'(GAP_CYC - 1) : '0;
  localparam logic [2:0] IDX_END = 3'(PKT_BYTES);

  pkt_phase_e       r_phase;
  logic [2:0]       r_idx;
  logic [15:0]      r_a;
  logic [15:0]      r_b;
  logic [GAP_W-1:0] r_gap;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;

  logic       w_ser_ready;
  logic       w_ser_valid;
  logic [7:0] w_ser_data;
  logic [7:0] w_byte;
  logic       w_tx;
  logic [2:0] w_ser_state;
  logic       w_accept;
  logic       w_last;

  assign w_accept = send && r_ready && (w_ser_state == ST_IDLE);
  // r_idx already points one past the byte on the line, so reaching IDX_END
  // means the footer is the one finishing.
  assign w_last   = (r_idx == IDX_END);

  // Byte select for the sequencer; header is fed directly on acceptance.
  always_comb begin
    w_byte = PKT_FOOTER;
    case (r_idx)
      IDX_HDR:  w_byte = PKT_HEADER;
      IDX_A_HI: w_byte = r_a[15:8];
      IDX_A_LO: w_byte = r_a[7:0];
      IDX_B_HI: w_byte = r_b[15:8];
      IDX_B_LO: w_byte = r_b[7:0];
`ifdef PRICE_PKT_CHECKSUM_EN
      IDX_CSUM: w_byte = r_a[15:8] ^ r_a[7:0] ^ r_b[15:8] ^ r_b[7:0];
`endif
      default:  w_byte = PKT_FOOTER;
    endcase
  end

  assign w_ser_valid = w_accept || ((r_phase == PH_SEND) && w_ser_ready && !w_last);
  assign w_ser_data  = (r_phase == PH_IDLE) ? PKT_HEADER : w_byte;

  uart_tx_serializer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk    (clk),
    .rst    (rst),
    .i_data (w_ser_data),
    .i_valid(w_ser_valid),
    .o_ready(w_ser_ready),
    .o_tx   (w_tx),
    .o_state(w_ser_state)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= PH_IDLE;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_gap   <= '0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_phase)
        PH_IDLE: begin
          if (w_accept) begin
            r_a     <= price_a;
            r_b     <= price_b;
            r_idx   <= 3'd1;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_phase <= PH_SEND;
          end
        end
        PH_SEND: begin
          // Serializer ready here means the current stop bit is ending.
          if (w_ser_ready) begin
            if (w_last) begin
              if (GAP_CYC == 0) begin
                r_idx   <= '0;
                r_ready <= 1'b1;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_phase <= PH_IDLE;
              end else begin
                r_gap   <= '0;
                r_phase <= PH_GAP;
              end
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end
        end
        PH_GAP: begin
          if (r_gap == GAP_LAST) begin
            r_idx   <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_phase <= PH_IDLE;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        default: r_phase <= PH_IDLE;
      endcase
    end
  end

  assign ready    = r_ready;
  assign busy     = r_busy;
  assign pkt_done = r_done;
  assign uart_tx  = w_tx;

endmodule

// File: tb/tb_price_packet_tx.sv
// -----------------------------------------------------------------------------
// tb_price_packet_tx
// Bench for price_packet_tx at a short bit time (1 MHz / 115200 -> 8 clocks
// per bit, truncated). A line receiver decodes every frame mid-bit and pops
// the expected byte pushed when the packet was accepted. A second instance
// with IDLE_BITS=2 covers the inter-packet gap.
// -----------------------------------------------------------------------------
module tb_price_packet_tx;

  localparam int CLK_FREQ  = 1_000_000;
  localparam int BAUD      = 115_200;
  localparam int CPB       = CLK_FREQ / BAUD;
`ifdef PRICE_PKT_CHECKSUM_EN
  localparam int N_FRAMES  = 7;
`else
  localparam int N_FRAMES  = 6;
`endif
  localparam int PKT_CYC   = N_FRAMES * 10 * CPB;
  localparam int GAP_BITS  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] price_a = '0;
  logic [15:0] price_b = '0;
  logic        send = 1'b0;
  logic        ready, uart_tx, busy, pkt_done;

  logic [15:0] g_price_a = 16'd4270;
  logic [15:0] g_price_b = 16'd4235;
  logic        g_send = 1'b0;
  logic        g_ready, g_tx, g_busy, g_done;

  price_packet_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .IDLE_BITS(0)) u_dut (
    .clk(clk), .rst(rst), .price_a(price_a), .price_b(price_b), .send(send),
    .ready(ready), .uart_tx(uart_tx), .busy(busy), .pkt_done(pkt_done)
  );

  price_packet_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .IDLE_BITS(GAP_BITS)) u_dut_gap (
    .clk(clk), .rst(rst), .price_a(g_price_a), .price_b(g_price_b), .send(g_send),
    .ready(g_ready), .uart_tx(g_tx), .busy(g_busy), .pkt_done(g_done)
  );

  // ---------------- scoreboard ----------------
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  int         t0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void push_pkt(input logic [15:0] a, input logic [15:0] b);
    exp_q.push_back(8'hAA);
    exp_q.push_back(a[15:8]);
    exp_q.push_back(a[7:0]);
    exp_q.push_back(b[15:8]);
    exp_q.push_back(b[7:0]);
`ifdef PRICE_PKT_CHECKSUM_EN
    exp_q.push_back(a[15:8] ^ a[7:0] ^ b[15:8] ^ b[7:0]);
`endif
    exp_q.push_back(8'h55);
  endfunction

  // ---------------- line receiver ----------------
  logic       m_act = 1'b0;
  int         m_idx = 0;
  int         m_frames = 0;
  logic       m_start;
  logic [7:0] m_data;
  logic [7:0] m_exp;

  always @(negedge clk) begin
    if (rst) begin
      m_act = 1'b0;
    end else if (!m_act) begin
      if (uart_tx === 1'b0) begin
        m_act = 1'b1;
        m_idx = 0;
      end
    end else begin
      m_idx++;
    end
    if (m_act && (m_idx % CPB == CPB / 2)) begin
      if (m_idx / CPB == 0) begin
        m_start = uart_tx;
      end else if (m_idx / CPB <= 8) begin
        m_data[m_idx / CPB - 1] = uart_tx;
      end else begin
        m_frames++;
        chk($sformatf("start_bit%0d", m_frames), 32'(m_start), 32'd0);
        chk($sformatf("stop_bit%0d", m_frames), 32'(uart_tx), 32'd1);
        chk($sformatf("frame_expected%0d", m_frames), 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          m_exp = exp_q.pop_front();
          chk($sformatf("frame_byte%0d", m_frames), 32'(m_data), 32'(m_exp));
        end
        m_act = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pkt(input logic [15:0] a, input logic [15:0] b, input string tag);
    int n = 0;
    while (!ready && n < 4 * PKT_CYC) begin
      tick();
      n++;
    end
    chk({tag, "_ready_before"}, 32'(ready), 32'd1);
    price_a = a;
    price_b = b;
    send    = 1'b1;
    tick();
    send    = 1'b0;
    push_pkt(a, b);
    // Inputs after acceptance must not matter.
    price_a = 16'($urandom_range(0, 65535));
    price_b = 16'($urandom_range(0, 65535));
    t0 = cyc;
    chk({tag, "_acc_ready"}, 32'(ready), 32'd0);
    chk({tag, "_acc_busy"}, 32'(busy), 32'd1);
    chk({tag, "_acc_start"}, 32'(uart_tx), 32'd0);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!pkt_done && n < 2 * PKT_CYC) begin
      tick();
      n++;
    end
    chk({tag, "_done_seen"}, 32'(pkt_done), 32'd1);
    chk({tag, "_latency"}, 32'(cyc - t0), 32'(PKT_CYC));
    chk({tag, "_done_ready"}, 32'(ready), 32'd1);
    chk({tag, "_done_busy"}, 32'(busy), 32'd0);
    chk({tag, "_all_frames"}, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic saw;
    logic [15:0] ra, rb;
    int t0g, n;

    // Reset held with send asserted: no start bit may appear.
    rst = 1'b1; send = 1'b1; price_a = 16'd4270; price_b = 16'd4235;
    saw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (uart_tx !== 1'b1 || busy !== 1'b0) saw = 1'b1;
    end
    chk("rst_quiet", 32'(saw), 32'd0);
    chk("rst_tx", 32'(uart_tx), 32'd1);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(pkt_done), 32'd0);
    chk("rst_gap_ready", 32'(g_ready), 32'd1);
    send = 1'b0;
    rst  = 1'b0;
    tick();

    // Single packet 4270 / 4235 -> AA 10 AE 10 8B [25] 55
    start_pkt(16'd4270, 16'd4235, "single");
    wait_done("single");
    tick();
    chk("done_width", 32'(pkt_done), 32'd0);
    chk("idle_line", 32'(uart_tx), 32'd1);

    // Request and price change while byte 2 is on the line are ignored.
    start_pkt(16'd4270, 16'd4235, "busy");
    repeat (23 * CPB) tick();
    price_a = 16'hFFFF;
    send    = 1'b1;
    tick();
    send    = 1'b0;
    wait_done("busy");
    saw = 1'b0;
    repeat (4 * CPB) begin
      tick();
      if (busy !== 1'b0 || uart_tx !== 1'b1) saw = 1'b1;
    end
    chk("no_queued_pkt", 32'(saw), 32'd0);

    // Framing bytes inside the payload are sent verbatim.
    start_pkt(16'hAA55, 16'h55AA, "framing");
    wait_done("framing");

    // Random prices.
    for (int i = 0; i < 2; i++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      start_pkt(ra, rb, $sformatf("rand%0d", i));
      wait_done($sformatf("rand%0d", i));
    end

    // Back-to-back with send held; second packet uses boundary prices.
    price_a = 16'd4270; price_b = 16'd4235; send = 1'b1;
    tick();
    push_pkt(16'd4270, 16'd4235);
    t0 = cyc;
    chk("b2b_first_start", 32'(uart_tx), 32'd0);
    price_a = 16'h0000; price_b = 16'hFFFF;
    wait_done("b2b1");
    push_pkt(16'h0000, 16'hFFFF);
    tick();
    chk("b2b_second_start", 32'(uart_tx), 32'd0);
    chk("b2b_second_busy", 32'(busy), 32'd1);
    chk("b2b_spacing", 32'(cyc - t0), 32'(PKT_CYC + 1));
    send = 1'b0;
    t0 = cyc;
    wait_done("b2b2");

    // Reset during the data bits of byte 3.
    start_pkt(16'd4270, 16'd4235, "abort");
    repeat (34 * CPB) tick();
    rst = 1'b1;
    exp_q.delete();
    tick();
    chk("mid_rst_tx", 32'(uart_tx), 32'd1);
    chk("mid_rst_ready", 32'(ready), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();
    start_pkt(16'd1234, 16'd5678, "after_rst");
    wait_done("after_rst");

    // IDLE_BITS=2 instance: gap length and back-to-back after the gap.
    g_send = 1'b1;
    tick();
    t0g = cyc;
    chk("gap_first_start", 32'(g_tx), 32'd0);
    n = 0;
    while (!g_done && n < 2 * PKT_CYC) begin
      tick();
      n++;
      if (cyc - t0g == PKT_CYC) begin
        chk("gap_busy", 32'(g_busy), 32'd1);
        chk("gap_not_ready", 32'(g_ready), 32'd0);
        chk("gap_line_high", 32'(g_tx), 32'd1);
      end
    end
    chk("gap_done_seen", 32'(g_done), 32'd1);
    chk("gap_latency", 32'(cyc - t0g), 32'(PKT_CYC + GAP_BITS * CPB));
    chk("gap_done_busy", 32'(g_busy), 32'd0);
    tick();
    chk("gap_b2b_start", 32'(g_tx), 32'd0);
    g_send = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
